cbus_sram_responder: RTL and testbench



---
 rtl/cbus_sram_responder_pkg.sv | 59 +++++
 rtl/cbus_sram_responder_sram_bytewrite.sv | 37 +++
 rtl/cbus_sram_responder.sv | 163 ++++++++++++++++
 tb/tb_cbus_sram_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cbus_sram_responder_pkg.sv
// Shared CBus definitions and local constants for the SRAM responder:
// request/response structs, MLEN and AXI burst encodings, FSM state type.
package cbus_sram_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  strb_t;
    typedef logic [2:0]  size_t;
    typedef logic [3:0]  mlen_t;
    typedef logic [1:0]  axi_burst_t;

    // MLEN: number of beats minus one
    localparam mlen_t MLEN1 = 4'd0;
    localparam mlen_t MLEN2 = 4'd1;
    localparam mlen_t MLEN4 = 4'd3;
    localparam mlen_t MLEN8 = 4'd7;

    localparam axi_burst_t AXI_BURST_FIXED = 2'b00;
    localparam axi_burst_t AXI_BURST_INCR  = 2'b01;
    localparam axi_burst_t AXI_BURST_WRAP  = 2'b10;

    // A burst holds up to 16 beats, so the remaining-beat counter needs 5 bits
    localparam int BEAT_CNT_W = 5;
    localparam int LAT_CNT_W  = 4;

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;
    typedef logic [LAT_CNT_W-1:0]  lat_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       is_write;
        size_t      size;
        addr_t      addr;
        strb_t      strobe;
        word_t      data;
        mlen_t      len;
        axi_burst_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  okay;
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    // Beat count for an MLEN encoding (len + 1)
    function automatic beat_cnt_t mlen_beats(input mlen_t len);
        return {1'b0, len} + beat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/cbus_sram_responder_sram_bytewrite.sv
// 1R1W word array with per-byte write enables and a combinational read port.
module cbus_sram_responder_sram_bytewrite
    import cbus_sram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  strb_t                wstrb,
    input  word_t                wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output word_t                rdata
);

    localparam int    DEPTH     = 1 << ADDR_BITS;
    localparam word_t INIT_WORD = INIT_ZERO ? '0 : 'x;

    word_t mem [DEPTH] = '{default: INIT_WORD};

    // Byte-granular write: only lanes with their strobe bit set are updated
    // NOTE: the array is deliberately outside any reset; clearing it would
    // need a multi-cycle sweep and contents must survive a bus reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cbus_sram_responder.sv
// CBus slave endpoint: accepts one request at a time and answers it with
// single or burst beats from an internal SRAM after a fixed access latency.
module cbus_sram_responder
    import cbus_sram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    typedef logic [ADDR_BITS-1:0] widx_t;

    // WAIT is entered with LATENCY-1 and leaves when the counter reads zero
    localparam lat_cnt_t LAT_LOAD = (LATENCY > 0) ? lat_cnt_t'(LATENCY - 1) : '0;

    state_e     state_q, state_d;
    beat_cnt_t  beats_q, beats_d;
    lat_cnt_t   lat_q, lat_d;
    widx_t      word_q, word_d;
    logic       is_write_q, is_write_d;
    axi_burst_t burst_q, burst_d;
    logic       ready_q, ready_d;
    logic       last_q, last_d;

    widx_t      base_word;
    beat_cnt_t  req_beats;
    logic       wr_en;
    word_t      rdata;

    // size, the byte offset and the address bits above the SRAM are ignored
    logic unused_req_bits;
    assign unused_req_bits = ^{creq.size, creq.addr[31:ADDR_BITS+2], creq.addr[1:0]};

    assign base_word = creq.addr[ADDR_BITS+1:2];
    assign req_beats = mlen_beats(creq.len);

    // A beat commits only while the initiator still holds valid, so a beat
    // cut short by an abort never reaches memory.
    assign wr_en = ready_q & creq.valid & is_write_q;

    cbus_sram_responder_sram_bytewrite #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_ZERO (INIT_ZERO)
    ) u_sram_bytewrite (
        .clk   (clk),
        .we    (wr_en),
        .waddr (word_q),
        .wstrb (creq.strobe),
        .wdata (creq.data),
        .raddr (word_q),
        .rdata (rdata)
    );

    // Next-state logic: transaction capture, latency countdown, beat sequencing
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        lat_d      = lat_q;
        word_d     = word_q;
        is_write_d = is_write_q;
        burst_d    = burst_q;
        ready_d    = 1'b0;
        last_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (creq.valid) begin
                    word_d     = base_word;
                    is_write_d = creq.is_write;
                    burst_d    = creq.burst;
                    beats_d    = req_beats;
                    if (LATENCY > 0) begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_LOAD;
                    end else begin
                        state_d = ST_BEAT;
                        ready_d = 1'b1;
                        last_d  = (req_beats == beat_cnt_t'(1));
                    end
                end
            end

            ST_WAIT: begin
                if (!creq.valid) begin
                    state_d = ST_IDLE;
                end else if (lat_q == '0) begin
                    state_d = ST_BEAT;
                    ready_d = 1'b1;
                    last_d  = (beats_q == beat_cnt_t'(1));
                end else begin
                    lat_d = lat_q - lat_cnt_t'(1);
                end
            end

            ST_BEAT: begin
                if (!creq.valid) begin
                    state_d = ST_IDLE;
                end else begin
                    beats_d = beats_q - beat_cnt_t'(1);
                    if (burst_q != AXI_BURST_FIXED) begin
                        word_d = word_q + widx_t'(1);
                    end
                    if (beats_q == beat_cnt_t'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        ready_d = 1'b1;
                        last_d  = (beats_q == beat_cnt_t'(2));
                    end
                end
            end

            ST_DRAIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            beats_q    <= '0;
            lat_q      <= '0;
            word_q     <= '0;
            is_write_q <= 1'b0;
            burst_q    <= AXI_BURST_FIXED;
            ready_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            lat_q      <= lat_d;
            word_q     <= word_d;
            is_write_q <= is_write_d;
            burst_q    <= burst_d;
            ready_q    <= ready_d;
            last_q     <= last_d;
        end
    end

    // Response: handshake flags straight from registers, data only during beats
    always_comb begin
        cresp       = '0;
        cresp.okay  = ready_q;
        cresp.ready = ready_q;
        cresp.last  = last_q;
        cresp.data  = ready_q ? rdata : '0;
    end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed self-checking bench for cbus_sram_responder (LATENCY=2, 4K words).
module tb_cbus_sram_responder;
    import cbus_sram_responder_pkg::*;

    localparam int ADDR_BITS = 12;
    localparam int LATENCY   = 2;

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int    checks = 0;
    int    errors = 0;
    word_t wbuf [16];
    word_t ebuf [16];

    cbus_sram_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LATENCY   (LATENCY),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .creq   (creq),
        .cresp  (cresp)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input addr_t addr, input mlen_t len,
                             input axi_burst_t burst, input strb_t strb);
        creq.valid    = 1'b1;
        creq.is_write = we;
        creq.size     = 3'd2;
        creq.addr     = addr;
        creq.strobe   = strb;
        creq.data     = wbuf[0];
        creq.len      = len;
        creq.burst    = burst;
    endtask

    // Advance until ready appears (bounded) and check the acceptance latency
    task automatic wait_ready(input string name);
        int waited = 0;
        do begin
            tick();
            waited++;
        end while (!cresp.ready && waited < 20);
        check({name, " latency"}, 64'(waited), 64'(LATENCY + 1));
    endtask

    // Complete burst: wbuf supplies write data, ebuf holds expected read data
    task automatic run_burst(input string name, input logic we, input addr_t addr,
                             input mlen_t len, input axi_burst_t burst, input strb_t strb);
        int n = int'(len) + 1;
        drive_req(we, addr, len, burst, strb);
        wait_ready(name);
        for (int b = 0; b < n; b++) begin
            if (we) creq.data = wbuf[b];
            check($sformatf("%s b%0d ready", name, b), 64'(cresp.ready), 64'(1));
            check($sformatf("%s b%0d okay", name, b), 64'(cresp.okay), 64'(1));
            check($sformatf("%s b%0d last", name, b), 64'(cresp.last), 64'(b == n - 1));
            if (!we) check($sformatf("%s b%0d data", name, b), 64'(cresp.data), 64'(ebuf[b]));
            tick();
        end
        check({name, " drain ready"}, 64'(cresp.ready), 64'(0));
        check({name, " drain last"}, 64'(cresp.last), 64'(0));
        creq.valid = 1'b0;
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        creq   = '0;

        // Reset held with a pending read: response must stay all-zero
        drive_req(1'b0, 32'h10, MLEN1, AXI_BURST_INCR, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset cresp c%0d", i), 64'(cresp), 64'(0));
        end
        resetn  = 1'b1;
        ebuf[0] = 32'h0;
        run_burst("rst_release_rd", 1'b0, 32'h10, MLEN1, AXI_BURST_INCR, 4'h0);

        // Single write then read back
        wbuf[0] = 32'hDEADBEEF;
        run_burst("wr_single", 1'b1, 32'h10, MLEN1, AXI_BURST_INCR, 4'hF);
        ebuf[0] = 32'hDEADBEEF;
        run_burst("rd_single", 1'b0, 32'h10, MLEN1, AXI_BURST_INCR, 4'h0);

        // Strobe merge
        wbuf[0] = 32'h11223344;
        run_burst("wr_preload", 1'b1, 32'h20, MLEN1, AXI_BURST_INCR, 4'hF);
        wbuf[0] = 32'hAABBCCDD;
        run_burst("wr_strb0101", 1'b1, 32'h20, MLEN1, AXI_BURST_INCR, 4'b0101);
        ebuf[0] = 32'h11BB33DD;
        run_burst("rd_merge", 1'b0, 32'h20, MLEN1, AXI_BURST_INCR, 4'h0);

        // Zero strobe: handshake completes, memory unchanged
        wbuf[0] = 32'h0;
        run_burst("wr_strb0", 1'b1, 32'h10, MLEN1, AXI_BURST_INCR, 4'h0);
        ebuf[0] = 32'hDEADBEEF;
        run_burst("rd_after_strb0", 1'b0, 32'h10, MLEN1, AXI_BURST_INCR, 4'h0);

        // INCR 4-beat write and read back
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = word_t'(i + 1);
            ebuf[i] = word_t'(i + 1);
        end
        run_burst("wr_incr4", 1'b1, 32'h100, MLEN4, AXI_BURST_INCR, 4'hF);
        run_burst("rd_incr4", 1'b0, 32'h100, MLEN4, AXI_BURST_INCR, 4'h0);

        // Reserved WRAP encoding behaves as INCR
        run_burst("rd_wrap_enc", 1'b0, 32'h100, MLEN2, AXI_BURST_WRAP, 4'h0);

        // Address wrap: 8 beats from word 4094 cover words 4094,4095,0..5
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 32'hA0 + word_t'(i);
            ebuf[i] = 32'hA0 + word_t'(i);
        end
        run_burst("wr_wrap8", 1'b1, 32'h3FF8, MLEN8, AXI_BURST_INCR, 4'hF);
        run_burst("rd_wrap8", 1'b0, 32'h3FF8, MLEN8, AXI_BURST_INCR, 4'h0);
        ebuf[0] = 32'hA2;
        run_burst("rd_word0", 1'b0, 32'h0, MLEN1, AXI_BURST_INCR, 4'h0);
        run_burst("rd_upper_ign", 1'b0, 32'h4000, MLEN1, AXI_BURST_INCR, 4'h0);
        ebuf[0] = 32'hA7;
        run_burst("rd_word5", 1'b0, 32'h14, MLEN1, AXI_BURST_INCR, 4'h0);

        // FIXED burst repeats the base word; byte offset bits ignored
        wbuf[0] = 32'hCAFEF00D;
        run_burst("wr_fixed_base", 1'b1, 32'h40, MLEN1, AXI_BURST_INCR, 4'hF);
        for (int i = 0; i < 4; i++) ebuf[i] = 32'hCAFEF00D;
        run_burst("rd_fixed4", 1'b0, 32'h43, MLEN4, AXI_BURST_FIXED, 4'h0);

        // Abort: valid drops after two beats of an 8-beat write
        for (int i = 0; i < 8; i++) wbuf[i] = 32'hB0 + word_t'(i);
        drive_req(1'b1, 32'h200, MLEN8, AXI_BURST_INCR, 4'hF);
        wait_ready("abort_wr");
        check("abort_wr b0 ready", 64'(cresp.ready), 64'(1));
        tick();
        creq.data = wbuf[1];
        check("abort_wr b1 ready", 64'(cresp.ready), 64'(1));
        tick();
        creq.valid = 1'b0;
        creq.data  = wbuf[2];
        tick();
        check("abort_wr ready after drop", 64'(cresp.ready), 64'(0));
        check("abort_wr last after drop", 64'(cresp.last), 64'(0));
        tick();
        ebuf[0] = 32'hB0;
        run_burst("rd_abort_w0", 1'b0, 32'h200, MLEN1, AXI_BURST_INCR, 4'h0);
        ebuf[0] = 32'hB1;
        run_burst("rd_abort_w1", 1'b0, 32'h204, MLEN1, AXI_BURST_INCR, 4'h0);
        ebuf[0] = 32'h0;
        run_burst("rd_abort_w2", 1'b0, 32'h208, MLEN1, AXI_BURST_INCR, 4'h0);

        // Mid-burst field changes ignored, then reset mid-burst
        drive_req(1'b0, 32'h100, MLEN4, AXI_BURST_INCR, 4'h0);
        wait_ready("midrst");
        check("midrst b0 data", 64'(cresp.data), 64'(32'h1));
        creq.addr = 32'h200;
        creq.len  = MLEN1;
        tick();
        check("midrst b1 data", 64'(cresp.data), 64'(32'h2));
        check("midrst b1 last", 64'(cresp.last), 64'(0));
        resetn = 1'b0;
        tick();
        check("midrst cresp", 64'(cresp), 64'(0));
        resetn     = 1'b1;
        creq.valid = 1'b0;
        tick();
        ebuf[0] = 32'h1;
        run_burst("rd_after_rst", 1'b0, 32'h100, MLEN1, AXI_BURST_INCR, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
